// File: rtl/rv64_pkg.sv
// rtl/rv64_pkg.sv - shared issue-queue defaults and wrap-around age compare
package rv64_pkg;

   localparam int DEF_IQ_DEPTH  = 16;
   localparam int DEF_AGE       = 5;
   localparam int DEF_PRF_WIDTH = 6;
   localparam int DEF_OPCODE    = 7;

   // a is older than b when b lies 1 .. half-1 steps ahead of a on the w-bit age ring
   function automatic logic age_older(input logic [31:0] a, input logic [31:0] b, input int w);
      logic [31:0] mask;
      logic [31:0] diff;
      logic [31:0] half;
      mask = (32'd1 << w) - 32'd1;
      diff = (b - a) & mask;
      half = 32'd1 << (w - 1);
      return (diff != 32'd0) && (diff < half);
   endfunction

endpackage

// File: rtl/iq_age_pick.sv
// rtl/iq_age_pick.sv - combinational oldest-eligible entry picker
module iq_age_pick
   import rv64_pkg::*;
#(
   parameter int N     = DEF_IQ_DEPTH,
   parameter int AGE   = DEF_AGE,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     eligible,
   input  logic [N*AGE-1:0] ages,
   output logic             found,
   output logic [IDX_W-1:0] index
);

   logic [AGE-1:0] best_age;

   // linear scan; a later entry replaces only when strictly older, so equal ages keep the lower index
   always_comb begin
      found    = 1'b0;
      index    = '0;
      best_age = '0;
      for (int i = 0; i < N; i++) begin
         if (eligible[i] &&
             (!found || age_older(32'(ages[i*AGE +: AGE]), 32'(best_age), AGE))) begin
            found    = 1'b1;
            index    = IDX_W'(i);
            best_age = ages[i*AGE +: AGE];
         end
      end
   end

endmodule

// File: rtl/iq_issue.sv
// rtl/iq_issue.sv - single-slot oldest-first issue select with free and wakeup pulses
module iq_issue
   import rv64_pkg::*;
#(
   parameter int IQ_DEPTH  = DEF_IQ_DEPTH,
   parameter int AGE       = DEF_AGE,
   parameter int PRF_WIDTH = DEF_PRF_WIDTH,
   parameter int OPCODE    = DEF_OPCODE
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [IQ_DEPTH-1:0]           ent_valid,
   input  logic [IQ_DEPTH-1:0]           ent_rdy,
   input  logic [IQ_DEPTH*AGE-1:0]       ent_age,
   input  logic [IQ_DEPTH*OPCODE-1:0]    ent_op,
   input  logic [IQ_DEPTH*PRF_WIDTH-1:0] ent_prd,
   input  logic [IQ_DEPTH-1:0]           ent_prd_v,
   input  logic                          flush,
   output logic                          iss_valid,
   input  logic                          iss_ready,
   output logic [$clog2(IQ_DEPTH)-1:0]   iss_idx,
   output logic [OPCODE-1:0]             iss_op,
   output logic [PRF_WIDTH-1:0]          iss_prd,
   output logic                          iss_prd_v,
   output logic                          free_valid,
   output logic [$clog2(IQ_DEPTH)-1:0]   free_idx,
   output logic                          wake_valid,
   output logic [PRF_WIDTH-1:0]          wake_tag
);

   localparam int IDX_W = $clog2(IQ_DEPTH);

   logic [IQ_DEPTH-1:0] issued;
   logic [IQ_DEPTH-1:0] slot_mask;
   logic [IQ_DEPTH-1:0] load_mask;
   logic [IQ_DEPTH-1:0] eligible;
   logic                pick_found;
   logic [IDX_W-1:0]    pick_idx;
   logic                slot_open;
   logic                load;
   logic                accept;

   // the slot's own entry is excluded so a cleared issued bit can never duplicate it
   always_comb begin
      slot_mask = '0;
      if (iss_valid) slot_mask[iss_idx] = 1'b1;
   end

   assign eligible  = ent_valid & ent_rdy & ~issued & ~slot_mask;
   assign slot_open = ~iss_valid | iss_ready;
   assign load      = slot_open & pick_found & ~flush;
   assign accept    = iss_valid & iss_ready & ~flush;

   iq_age_pick #(
      .N     (IQ_DEPTH),
      .AGE   (AGE),
      .IDX_W (IDX_W)
   ) u_pick (
      .eligible (eligible),
      .ages     (ent_age),
      .found    (pick_found),
      .index    (pick_idx)
   );

   // one-hot of the entry being moved into the slot this cycle
   always_comb begin
      load_mask = '0;
      if (load) load_mask[pick_idx] = 1'b1;
   end

   // issue slot: refill whenever it is empty or being accepted; hold while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_valid <= 1'b0;
         iss_idx   <= '0;
         iss_op    <= '0;
         iss_prd   <= '0;
         iss_prd_v <= 1'b0;
      end else if (flush) begin
         iss_valid <= 1'b0;
      end else if (slot_open) begin
         iss_valid <= pick_found;
         if (pick_found) begin
            iss_idx   <= pick_idx;
            iss_op    <= ent_op[pick_idx*OPCODE +: OPCODE];
            iss_prd   <= ent_prd[pick_idx*PRF_WIDTH +: PRF_WIDTH];
            iss_prd_v <= ent_prd_v[pick_idx];
         end
      end
   end

   // acceptance turns into single-cycle free and wakeup pulses; flush swallows them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         free_valid <= 1'b0;
         free_idx   <= '0;
         wake_valid <= 1'b0;
         wake_tag   <= '0;
      end else begin
         free_valid <= accept;
         wake_valid <= accept & iss_prd_v;
         if (accept) begin
            free_idx <= iss_idx;
            wake_tag <= iss_prd;
         end
      end
   end

   // issued bits survive until the queue deallocates the entry, covering the free-to-dealloc gap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issued <= '0;
      end else if (flush) begin
         issued <= '0;
      end else begin
         issued <= (issued & ent_valid) | load_mask;
      end
   end

endmodule

// File: tb/tb_iq_issue.sv
// tb/tb_iq_issue.sv - self-checking bench for iq_issue
module tb_iq_issue;

   localparam int N  = 16;
   localparam int AW = 5;
   localparam int PW = 6;
   localparam int OW = 7;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    ent_valid;
   logic [N-1:0]    ent_rdy;
   logic [N*AW-1:0] ent_age;
   logic [N*OW-1:0] ent_op;
   logic [N*PW-1:0] ent_prd;
   logic [N-1:0]    ent_prd_v;
   logic            flush;
   logic            iss_valid;
   logic            iss_ready;
   logic [3:0]      iss_idx;
   logic [OW-1:0]   iss_op;
   logic [PW-1:0]   iss_prd;
   logic            iss_prd_v;
   logic            free_valid;
   logic [3:0]      free_idx;
   logic            wake_valid;
   logic [PW-1:0]   wake_tag;

   always #5 clk = ~clk;

   iq_issue #(
      .IQ_DEPTH  (N),
      .AGE       (AW),
      .PRF_WIDTH (PW),
      .OPCODE    (OW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ent_valid  (ent_valid),
      .ent_rdy    (ent_rdy),
      .ent_age    (ent_age),
      .ent_op     (ent_op),
      .ent_prd    (ent_prd),
      .ent_prd_v  (ent_prd_v),
      .flush      (flush),
      .iss_valid  (iss_valid),
      .iss_ready  (iss_ready),
      .iss_idx    (iss_idx),
      .iss_op     (iss_op),
      .iss_prd    (iss_prd),
      .iss_prd_v  (iss_prd_v),
      .free_valid (free_valid),
      .free_idx   (free_idx),
      .wake_valid (wake_valid),
      .wake_tag   (wake_tag)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int age_a[N];
   int op_a[N];
   int prd_a[N];

   typedef struct {
      logic [15:0] valid;
      logic [15:0] rdy;
      int          dflt;
      int          ia;
      int          aa;
      int          ib;
      int          ab;
      logic        exp_v;
      int          exp_idx;
   } vec_t;

   vec_t vecs[$];

   // reference model state
   bit          m_v;
   int          m_idx, m_op, m_prd;
   bit          m_prdv;
   bit          m_issued[N];
   bit          m_free_v, m_wake_v;
   int          m_free_idx, m_wake_tag;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic pack_inputs();
      for (int i = 0; i < N; i++) begin
         ent_age[i*AW +: AW] = AW'(age_a[i]);
         ent_op[i*OW +: OW]  = OW'(op_a[i]);
         ent_prd[i*PW +: PW] = PW'(prd_a[i]);
      end
   endtask

   task automatic clear_inputs();
      ent_valid = '0;
      ent_rdy   = '0;
      ent_prd_v = '0;
      flush     = 1'b0;
      iss_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         age_a[i] = 0;
         op_a[i]  = 0;
         prd_a[i] = 0;
      end
      pack_inputs();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush();
      flush     = 1'b1;
      ent_valid = '0;
      step();
      flush = 1'b0;
   endtask

   // model: oldest = smallest distance from the cycle's age base; slot entry and issued entries excluded
   task automatic model_cycle(input int base);
      bit acc, pf;
      int pi, best_rel, rel;
      acc = m_v && iss_ready;
      if (flush) begin
         m_v      = 0;
         m_free_v = 0;
         m_wake_v = 0;
         for (int i = 0; i < N; i++) m_issued[i] = 0;
      end else begin
         m_free_v = acc;
         m_wake_v = acc && m_prdv;
         if (acc) begin
            m_free_idx = m_idx;
            m_wake_tag = m_prd;
         end
         pf = 0;
         pi = 0;
         best_rel = 1000;
         if (!m_v || iss_ready) begin
            for (int i = 0; i < N; i++) begin
               if (ent_valid[i] && ent_rdy[i] && !m_issued[i] && !(m_v && m_idx == i)) begin
                  rel = (age_a[i] - base + 32) % 32;
                  if (rel < best_rel) begin
                     best_rel = rel;
                     pi = i;
                     pf = 1;
                  end
               end
            end
         end
         for (int i = 0; i < N; i++) if (!ent_valid[i]) m_issued[i] = 0;
         if (!m_v || iss_ready) begin
            m_v = pf;
            if (pf) begin
               m_idx  = pi;
               m_op   = op_a[pi];
               m_prd  = prd_a[pi];
               m_prdv = ent_prd_v[pi];
               m_issued[pi] = 1;
            end
         end
      end
   endtask

   initial begin
      int base;

      // reset state, asserted away from any clock edge
      rst_n = 1'b1;
      clear_inputs();
      #1 rst_n = 1'b0;
      #1;
      check("rst_iss_valid", iss_valid, 0);
      check("rst_free_valid", free_valid, 0);
      check("rst_wake_valid", wake_valid, 0);
      check("rst_iss_idx", iss_idx, 0);
      check("rst_wake_tag", wake_tag, 0);
      step();
      step();
      // first select at the first edge after release
      ent_valid[3] = 1'b1;
      ent_rdy[3]   = 1'b1;
      rst_n = 1'b1;
      step();
      check("first_sel_valid", iss_valid, 1);
      check("first_sel_idx", iss_idx, 3);

      // table-driven single-cycle select from an empty slot
      vecs.push_back('{16'h0000, 16'hFFFF, 0, 0, 0, 0, 0, 1'b0, 0});
      vecs.push_back('{16'h0208, 16'h0208, 0, 3, 7, 9, 4, 1'b1, 9});
      vecs.push_back('{16'h0024, 16'h0024, 0, 2, 30, 5, 1, 1'b1, 2});
      vecs.push_back('{16'h0810, 16'h0810, 10, 4, 10, 11, 10, 1'b1, 4});
      vecs.push_back('{16'h0208, 16'h0008, 0, 3, 7, 9, 4, 1'b1, 3});
      vecs.push_back('{16'h0008, 16'h0208, 0, 3, 7, 9, 4, 1'b1, 3});
      vecs.push_back('{16'h8001, 16'h8001, 0, 0, 0, 15, 15, 1'b1, 0});
      vecs.push_back('{16'h8001, 16'h8001, 0, 0, 0, 15, 17, 1'b1, 15});
      vecs.push_back('{16'h4002, 16'h4002, 0, 1, 31, 14, 0, 1'b1, 1});
      for (int k = 0; k < vecs.size(); k++) begin
         clear_inputs();
         do_flush();
         for (int i = 0; i < N; i++) age_a[i] = vecs[k].dflt;
         age_a[vecs[k].ia] = vecs[k].aa;
         age_a[vecs[k].ib] = vecs[k].ab;
         pack_inputs();
         ent_valid = vecs[k].valid;
         ent_rdy   = vecs[k].rdy;
         step();
         check($sformatf("vec%0d_valid", k), iss_valid, vecs[k].exp_v);
         if (vecs[k].exp_v) check($sformatf("vec%0d_idx", k), iss_idx, vecs[k].exp_idx);
      end

      // back-to-back issue of entries 9 then 3 with free and wakeup pulses
      clear_inputs();
      do_flush();
      age_a[3] = 7;  prd_a[3] = 11;
      age_a[9] = 4;  prd_a[9] = 22;
      pack_inputs();
      ent_valid = 16'h0208; ent_rdy = 16'h0208; ent_prd_v = 16'h0208;
      iss_ready = 1'b1;
      step();
      check("b2b_idx0", iss_idx, 9);
      check("b2b_prd0", iss_prd, 22);
      check("b2b_free0", free_valid, 0);
      step();
      check("b2b_idx1", iss_idx, 3);
      check("b2b_free1", free_valid, 1);
      check("b2b_free_idx1", free_idx, 9);
      check("b2b_wake1", wake_valid, 1);
      check("b2b_wake_tag1", wake_tag, 22);
      step();
      check("b2b_empty", iss_valid, 0);
      check("b2b_free_idx2", free_idx, 3);
      check("b2b_wake_tag2", wake_tag, 11);
      step();
      check("b2b_free_end", free_valid, 0);
      check("b2b_wake_end", wake_valid, 0);

      // stall holds the slot; release gives one free pulse
      clear_inputs();
      do_flush();
      op_a[4] = 51; prd_a[4] = 5;
      pack_inputs();
      ent_valid[4] = 1'b1; ent_rdy[4] = 1'b1; ent_prd_v[4] = 1'b1;
      step();
      check("stall_load", iss_idx, 4);
      for (int c = 0; c < 3; c++) begin
         step();
         check("stall_valid", iss_valid, 1);
         check("stall_idx", iss_idx, 4);
         check("stall_op", iss_op, 51);
         check("stall_prd", iss_prd, 5);
         check("stall_free", free_valid, 0);
         check("stall_wake", wake_valid, 0);
      end
      iss_ready = 1'b1;
      step();
      check("stall_rel_free", free_valid, 1);
      check("stall_rel_idx", free_idx, 4);
      check("stall_rel_wake", wake_tag, 5);
      check("stall_rel_empty", iss_valid, 0);
      step();
      check("stall_single_pulse", free_valid, 0);

      // no reissue while the freed entry lingers, reissue after dealloc and realloc
      clear_inputs();
      do_flush();
      ent_valid[6] = 1'b1; ent_rdy[6] = 1'b1; ent_prd_v[6] = 1'b1;
      iss_ready = 1'b1;
      step();
      check("reiss_first", iss_idx, 6);
      step();
      check("reiss_free", free_idx, 6);
      check("reiss_gap1", iss_valid, 0);
      step();
      check("reiss_gap2", iss_valid, 0);
      ent_valid[6] = 1'b0;
      step();
      check("reiss_dealloc", iss_valid, 0);
      ent_valid[6] = 1'b1;
      step();
      check("reiss_again_v", iss_valid, 1);
      check("reiss_again_idx", iss_idx, 6);

      // flush discards a coincident acceptance and clears issued
      clear_inputs();
      do_flush();
      prd_a[5] = 9;
      pack_inputs();
      ent_valid[5] = 1'b1; ent_rdy[5] = 1'b1; ent_prd_v[5] = 1'b1;
      iss_ready = 1'b1;
      step();
      check("flush_pre", iss_valid, 1);
      flush = 1'b1;
      step();
      check("flush_iss", iss_valid, 0);
      check("flush_free", free_valid, 0);
      check("flush_wake", wake_valid, 0);
      flush = 1'b0;
      step();
      check("flush_reissue_v", iss_valid, 1);
      check("flush_reissue_idx", iss_idx, 5);

      // asynchronous reset in the middle of a stall
      clear_inputs();
      do_flush();
      op_a[4] = 99; prd_a[4] = 17;
      pack_inputs();
      ent_valid[4] = 1'b1; ent_rdy[4] = 1'b1; ent_prd_v[4] = 1'b1;
      step();
      check("arst_pre", iss_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_iss_valid", iss_valid, 0);
      check("arst_iss_idx", iss_idx, 0);
      check("arst_iss_op", iss_op, 0);
      check("arst_iss_prd", iss_prd, 0);
      check("arst_prd_v", iss_prd_v, 0);
      check("arst_free_valid", free_valid, 0);
      check("arst_wake_valid", wake_valid, 0);
      step();
      rst_n = 1'b1;

      // randomized traffic against the reference model
      clear_inputs();
      do_flush();
      m_v = 0; m_free_v = 0; m_wake_v = 0;
      m_idx = 0; m_op = 0; m_prd = 0; m_prdv = 0;
      m_free_idx = 0; m_wake_tag = 0;
      for (int i = 0; i < N; i++) m_issued[i] = 0;
      for (int c = 0; c < 3000; c++) begin
         base = $urandom_range(0, 31);
         for (int i = 0; i < N; i++) begin
            age_a[i] = (base + $urandom_range(0, 14)) % 32;
            op_a[i]  = $urandom_range(0, 127);
            prd_a[i] = $urandom_range(0, 63);
         end
         pack_inputs();
         ent_valid = N'($urandom);
         ent_rdy   = N'($urandom);
         ent_prd_v = N'($urandom);
         iss_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         model_cycle(base);
         step();
         check("rnd_iss_valid", iss_valid, m_v);
         if (m_v) begin
            check("rnd_iss_idx", iss_idx, m_idx);
            check("rnd_iss_op", iss_op, m_op);
            check("rnd_iss_prd", iss_prd, m_prd);
            check("rnd_iss_prd_v", iss_prd_v, m_prdv);
         end
         check("rnd_free_valid", free_valid, m_free_v);
         if (m_free_v) check("rnd_free_idx", free_idx, m_free_idx);
         check("rnd_wake_valid", wake_valid, m_wake_v);
         if (m_wake_v) check("rnd_wake_tag", wake_tag, m_wake_tag);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
